// File: rtl/rf_pkg.sv
// rf_pkg: shared state type and packed-port helper for the register file
package rf_pkg;
  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/rf_clear_sequencer.sv
// rf_clear_sequencer: walks every address once after reset, then reports ready
import rf_pkg::*;
module rf_clear_sequencer #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic                  Busy,
  output logic                  ClearActive,
  output logic                  ClearWrite,
  output logic [ADDR_WIDTH-1:0] ClearAddress
);
  rf_state_t state, state_next;
  logic [ADDR_WIDTH-1:0] count, count_next;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= RF_CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end
  // count wraps to 0 on the same edge that leaves CLEAR
  always_comb begin
    state_next = (state == RF_CLEAR && &count) ? RF_READY : state;
    count_next = (state == RF_CLEAR) ? count + 1'b1 : count;
  end
  assign ClearActive  = state == RF_CLEAR;
  assign Busy         = ClearActive;
  assign ClearWrite   = ClearActive && !Reset;
  assign ClearAddress = count;
endmodule

// File: rtl/multi_port_register_file.sv
// multi_port_register_file: 2W/NR register file with bypass, zero reg and hardware clear
import rf_pkg::*;
module multi_port_register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           WriteEnableA,
  input  logic [ADDR_WIDTH-1:0]          WriteAddressA,
  input  logic [DATA_WIDTH-1:0]          WriteDataA,
  input  logic                           WriteEnableB,
  input  logic [ADDR_WIDTH-1:0]          WriteAddressB,
  input  logic [DATA_WIDTH-1:0]          WriteDataB,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadAddress,
  output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
  output logic                           Busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic clear_active, clear_write, we_a, we_b;
  logic [ADDR_WIDTH-1:0] clear_addr;
  rf_clear_sequencer #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
    .Clock(Clock),
    .Reset(Reset),
    .Busy(Busy),
    .ClearActive(clear_active),
    .ClearWrite(clear_write),
    .ClearAddress(clear_addr)
  );
  // qualified enables: ignored while clearing and for a hardwired zero register
  assign we_a = WriteEnableA && !clear_active && !(ZERO_REG != 0 && WriteAddressA == '0);
  assign we_b = WriteEnableB && !clear_active && !(ZERO_REG != 0 && WriteAddressB == '0);
  always_ff @(posedge Clock) begin
    if (clear_write) regs[clear_addr] <= '0;
    if (we_a) regs[WriteAddressA] <= WriteDataA;
    if (we_b) regs[WriteAddressB] <= WriteDataB;
  end
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic hit_a, hit_b, zero_hit;
    assign ra       = ReadAddress[port_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
    assign hit_a    = BYPASS != 0 && we_a && WriteAddressA == ra;
    assign hit_b    = BYPASS != 0 && we_b && WriteAddressB == ra;
    assign zero_hit = ZERO_REG != 0 && ra == '0;
    assign ReadData[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
      (clear_active || zero_hit) ? '0 : hit_b ? WriteDataB : hit_a ? WriteDataA : regs[ra];
  end
endmodule
